// File: rtl/ahbl_to_apb_if.sv
// ---------------------------------------------------------------------------
// ahbl_to_apb_if
// Bundles the AHB-Lite slave port and the APB master port of the bridge.
//   slave  modport : the bridge's view (AHB-Lite slave in, APB master out)
//   master modport : the environment's view (AHB master + APB slave)
// AHB side : ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans,
//            ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
//            ahbls_hwdata -> bridge; ahbls_hready_resp, ahbls_hresp,
//            ahbls_hrdata <- bridge
// APB side : apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata
//            <- bridge; apbm_prdata, apbm_pready, apbm_pslverr -> bridge
// ---------------------------------------------------------------------------
interface ahbl_to_apb_if #(
   parameter int W_HADDR = 32,
   parameter int W_PADDR = 16,
   parameter int W_DATA  = 32
);
   logic               ahbls_hready;
   logic               ahbls_hready_resp;
   logic               ahbls_hresp;
   logic [W_HADDR-1:0] ahbls_haddr;
   logic               ahbls_hwrite;
   logic [1:0]         ahbls_htrans;
   logic [2:0]         ahbls_hsize;
   logic [2:0]         ahbls_hburst;
   logic [3:0]         ahbls_hprot;
   logic               ahbls_hmastlock;
   logic [W_DATA-1:0]  ahbls_hwdata;
   logic [W_DATA-1:0]  ahbls_hrdata;

   logic [W_PADDR-1:0] apbm_paddr;
   logic               apbm_psel;
   logic               apbm_penable;
   logic               apbm_pwrite;
   logic [W_DATA-1:0]  apbm_pwdata;
   logic [W_DATA-1:0]  apbm_prdata;
   logic               apbm_pready;
   logic               apbm_pslverr;

   modport slave (
      input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans,
             ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
             ahbls_hwdata,
      output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
      output apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata,
      input  apbm_prdata, apbm_pready, apbm_pslverr
   );

   modport master (
      output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans,
             ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
             ahbls_hwdata,
      input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
      input  apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata,
      output apbm_prdata, apbm_pready, apbm_pslverr
   );
endinterface

// File: rtl/ahbl_to_apb.sv
// ---------------------------------------------------------------------------
// ahbl_to_apb
// AHB-Lite slave to APB master bridge. One APB transfer per AHB transfer;
// reads take one AHB wait state plus APB waits, writes two (the extra
// WDATA cycle captures the AHB data-phase write data). APB errors are
// returned as the two-cycle AHB ERROR response (ERR1, ERR2).
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ahbl_to_apb_if.slave (AHB-Lite slave + APB master signals)
// ---------------------------------------------------------------------------
module ahbl_to_apb #(
   parameter int W_HADDR = 32,
   parameter int W_PADDR = 16,
   parameter int W_DATA  = 32
) (
   input logic           clk,
   input logic           rst_n,
   ahbl_to_apb_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
   } state_e;

   state_e             state_q, state_d;
   logic [W_PADDR-1:0] paddr_q, paddr_d;
   logic               pwrite_q, pwrite_d;
   logic [W_DATA-1:0]  pwdata_q, pwdata_d;

   logic               access_ok;
   logic               accept;
   logic               hready_resp;
   logic               hresp;
   logic [W_DATA-1:0]  hrdata;
   logic               psel;
   logic               penable;

   // ACCESS finishing cleanly frees the bridge in the same cycle, so a new
   // address phase can be taken there (back-to-back transfers).
   assign access_ok = (state_q == S_ACCESS) && bus.apbm_pready && !bus.apbm_pslverr;
   assign accept    = bus.ahbls_hready && bus.ahbls_htrans[1] &&
                      ((state_q == S_IDLE) || (state_q == S_ERR2) || access_ok);

   // NOTE: every variable written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      hready_resp = 1'b0;
      hresp       = 1'b0;
      hrdata      = '0;
      psel        = 1'b0;
      penable     = 1'b0;

      case (state_q)
         S_IDLE: begin
            hready_resp = 1'b1;
            state_d     = S_IDLE;
         end
         S_WDATA: begin
            pwdata_d = bus.ahbls_hwdata;
            state_d  = S_SETUP;
         end
         S_SETUP: begin
            psel    = 1'b1;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            hrdata  = bus.apbm_prdata;
            if (bus.apbm_pready) begin
               if (bus.apbm_pslverr) begin
                  state_d = S_ERR1;
               end else begin
                  hready_resp = 1'b1;
                  state_d     = S_IDLE;
               end
            end
         end
         S_ERR1: begin
            hresp   = 1'b1;
            state_d = S_ERR2;
         end
         S_ERR2: begin
            hready_resp = 1'b1;
            hresp       = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Acceptance overrides the fall-back to IDLE chosen above.
      if (accept) begin
         paddr_d  = bus.ahbls_haddr[W_PADDR-1:0];
         pwrite_d = bus.ahbls_hwrite;
         state_d  = bus.ahbls_hwrite ? S_WDATA : S_SETUP;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
      end
   end

   // psel/penable decode straight from state, so reset drops them at once.
   assign bus.ahbls_hready_resp = hready_resp;
   assign bus.ahbls_hresp       = hresp;
   assign bus.ahbls_hrdata      = hrdata;
   assign bus.apbm_paddr        = paddr_q;
   assign bus.apbm_pwrite       = pwrite_q;
   assign bus.apbm_pwdata       = pwdata_q;
   assign bus.apbm_psel         = psel;
   assign bus.apbm_penable      = penable;

   // Attributes the bridge has no use for, and address bits above W_PADDR.
   logic unused_inputs;
   assign unused_inputs = ^{bus.ahbls_hsize, bus.ahbls_hburst, bus.ahbls_hprot,
                            bus.ahbls_hmastlock, bus.ahbls_haddr, bus.ahbls_htrans[0]};

endmodule

// File: tb/tb_ahbl_to_apb.sv
// ---------------------------------------------------------------------------
// tb_ahbl_to_apb
// Drives AHB transfers from a vector table through the bridge and models a
// simple APB slave whose wait states, error flag and read data come from
// the vector currently on the APB bus. Accepted transfers are queued as
// expectations; the APB monitor pops them when the transfer completes.
// ---------------------------------------------------------------------------
module tb_ahbl_to_apb;
   localparam int W_HADDR = 32;
   localparam int W_PADDR = 16;
   localparam int W_DATA  = 32;

   typedef struct {
      logic        write;
      logic [31:0] haddr;
      logic [31:0] wdata;
      logic [31:0] prdata;
      int          wait_n;
      logic        slverr;
      logic [15:0] exp_paddr;
      logic [31:0] exp_hrdata;
      logic        exp_hresp;
      int          exp_cycles;   // AHB data-phase cycles including the last
      int          exp_pen;      // cycles with penable high
      logic        exp_no_gap;   // SETUP must follow the previous ACCESS directly
   } vec_t;

   vec_t tbl[7];
   vec_t sb_q[$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hready_block = 1'b0;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          acc_cnt;
   int          cur_wait   = 0;
   logic        cur_slverr = 1'b0;
   logic [31:0] cur_prdata = 32'h0;
   int          pen_cnt  = 0;
   int          psel_gap = 0;

   ahbl_to_apb_if #(.W_HADDR(W_HADDR), .W_PADDR(W_PADDR), .W_DATA(W_DATA)) bus();

   ahbl_to_apb #(.W_HADDR(W_HADDR), .W_PADDR(W_PADDR), .W_DATA(W_DATA)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Single-slave system: bus HREADY follows this slave unless forced low.
   assign bus.ahbls_hready = bus.ahbls_hready_resp & ~hready_block;

   // APB slave model.
   assign bus.apbm_pready  = bus.apbm_psel & bus.apbm_penable & (acc_cnt == cur_wait);
   assign bus.apbm_pslverr = bus.apbm_pready & cur_slverr;
   assign bus.apbm_prdata  = cur_prdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_cnt <= 0;
      else if (bus.apbm_psel && bus.apbm_penable && !bus.apbm_pready)
         acc_cnt <= acc_cnt + 1;
      else
         acc_cnt <= 0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // APB monitor / scoreboard consumer.
   always @(negedge clk) begin
      if (rst_n && bus.apbm_psel && !bus.apbm_penable) begin
         pen_cnt = 0;
         if (sb_q.size() == 0) begin
            check("sb_underflow_setup", 32'd0, 32'd1);
         end else begin
            cur_wait   = sb_q[0].wait_n;
            cur_slverr = sb_q[0].slverr;
            cur_prdata = sb_q[0].prdata;
            if (sb_q[0].exp_no_gap) check("psel_gap", psel_gap, 0);
            if (sb_q[0].write) check("pwdata_setup", bus.apbm_pwdata, sb_q[0].wdata);
         end
      end
      if (rst_n && bus.apbm_psel && bus.apbm_penable) begin
         pen_cnt++;
         if (bus.apbm_pready) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow_access", 32'd0, 32'd1);
            end else begin
               vec_t e;
               e = sb_q.pop_front();
               check($sformatf("paddr_%04h", e.exp_paddr), bus.apbm_paddr, e.exp_paddr);
               check($sformatf("pwrite_%04h", e.exp_paddr), bus.apbm_pwrite, e.write);
               if (e.write) check($sformatf("pwdata_%04h", e.exp_paddr), bus.apbm_pwdata, e.wdata);
               check($sformatf("penable_cycles_%04h", e.exp_paddr), pen_cnt, e.exp_pen);
            end
            psel_gap = 0;
         end
      end else if (!bus.apbm_psel) begin
         psel_gap++;
      end
   end

   task automatic drive_addr(input int idx);
      bus.ahbls_haddr  = tbl[idx].haddr;
      bus.ahbls_hwrite = tbl[idx].write;
      bus.ahbls_htrans = 2'b10;
   endtask

   task automatic idle_addr();
      bus.ahbls_haddr  = '0;
      bus.ahbls_hwrite = 1'b0;
      bus.ahbls_htrans = 2'b00;
   endtask

   // Pipelined AHB master: the next address is presented during the current
   // data phase and taken on the same HREADY-high edge that completes it.
   task automatic run_burst(input int first, input int count);
      int nxt, dp_idx, lat, guard;
      bit dp_act, err_seen;
      nxt = first; dp_idx = 0; lat = 0; guard = 0; dp_act = 0; err_seen = 0;
      @(posedge clk); #1;
      drive_addr(first);
      while ((nxt < first + count || dp_act) && guard < 200) begin
         @(negedge clk);
         guard++;
         if (dp_act) begin
            lat++;
            if (bus.ahbls_hresp && !bus.ahbls_hready_resp) err_seen = 1;
         end
         if (bus.ahbls_hready) begin
            if (dp_act) begin
               check($sformatf("v%0d_cycles", dp_idx), lat, tbl[dp_idx].exp_cycles);
               check($sformatf("v%0d_hresp", dp_idx), bus.ahbls_hresp, tbl[dp_idx].exp_hresp);
               check($sformatf("v%0d_err_first", dp_idx), err_seen, tbl[dp_idx].exp_hresp);
               if (!tbl[dp_idx].write)
                  check($sformatf("v%0d_hrdata", dp_idx), bus.ahbls_hrdata, tbl[dp_idx].exp_hrdata);
            end
            dp_act = 0;
            if (nxt < first + count) begin
               dp_act   = 1;
               dp_idx   = nxt;
               lat      = 0;
               err_seen = 0;
               sb_q.push_back(tbl[nxt]);
               nxt++;
            end
            @(posedge clk); #1;
            bus.ahbls_hwdata = dp_act ? tbl[dp_idx].wdata : 32'h0;
            if (nxt < first + count) drive_addr(nxt);
            else idle_addr();
         end
      end
      if (nxt < first + count || dp_act) check("burst_timeout", 32'd1, 32'd0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_psel"}, bus.apbm_psel, 1'b0);
      check({tag, "_penable"}, bus.apbm_penable, 1'b0);
      check({tag, "_hready_resp"}, bus.ahbls_hready_resp, 1'b1);
      check({tag, "_hresp"}, bus.ahbls_hresp, 1'b0);
      check({tag, "_hrdata"}, bus.ahbls_hrdata, 32'h0);
   endtask

   initial begin
      // write haddr wdata prdata wait err | paddr hrdata hresp cycles pen nogap
      tbl[0] = '{1'b0, 32'h4000_1234, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 16'h1234, 32'hCAFE_F00D, 1'b0, 2, 1, 1'b0};
      tbl[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 3, 1'b0, 16'h0010, 32'h0, 1'b0, 6, 4, 1'b0};
      tbl[2] = '{1'b0, 32'h0000_2000, 32'h0, 32'h1357_9BDF, 1, 1'b1, 16'h2000, 32'h0, 1'b1, 5, 2, 1'b0};
      tbl[3] = '{1'b1, 32'hABCD_5678, 32'h1234_5678, 32'h0, 0, 1'b0, 16'h5678, 32'h0, 1'b0, 3, 1, 1'b0};
      tbl[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_5A5A, 2, 1'b0, 16'hFFFC, 32'hA5A5_5A5A, 1'b0, 4, 3, 1'b0};
      tbl[5] = '{1'b1, 32'h0000_0100, 32'h1111_2222, 32'h0, 1, 1'b0, 16'h0100, 32'h0, 1'b0, 4, 2, 1'b0};
      tbl[6] = '{1'b0, 32'h0000_0104, 32'h0, 32'h3333_4444, 0, 1'b0, 16'h0104, 32'h3333_4444, 1'b0, 2, 1, 1'b1};

      rst_n                = 1'b0;
      bus.ahbls_hsize      = 3'b010;
      bus.ahbls_hburst     = 3'b000;
      bus.ahbls_hprot      = 4'b0011;
      bus.ahbls_hmastlock  = 1'b0;
      bus.ahbls_hwdata     = '0;
      idle_addr();

      // Reset state.
      repeat (2) @(negedge clk);
      check_idle("reset");
      check("reset_paddr", bus.apbm_paddr, 16'h0);
      check("reset_pwdata", bus.apbm_pwdata, 32'h0);
      rst_n = 1'b1;

      // Single transfers: read, write with waits, error read, upper-bit
      // discard, read with waits.
      for (int i = 0; i < 5; i++) begin
         run_burst(i, 1);
         @(negedge clk);
         check_idle($sformatf("after_v%0d", i));
      end

      // Back-to-back write then read.
      run_burst(5, 2);
      @(negedge clk);
      check_idle("after_b2b");

      // BUSY transfers, then NSEQ while HREADY is low: both ignored.
      @(posedge clk); #1;
      bus.ahbls_haddr  = 32'h0000_0BB0;
      bus.ahbls_hwrite = 1'b1;
      bus.ahbls_htrans = 2'b01;
      repeat (3) @(negedge clk) begin
         check("busy_psel", bus.apbm_psel, 1'b0);
         check("busy_hready_resp", bus.ahbls_hready_resp, 1'b1);
      end
      @(posedge clk); #1;
      hready_block     = 1'b1;
      bus.ahbls_htrans = 2'b10;
      repeat (3) @(negedge clk) begin
         check("nready_psel", bus.apbm_psel, 1'b0);
         check("nready_hready_resp", bus.ahbls_hready_resp, 1'b1);
      end
      @(posedge clk); #1;
      idle_addr();
      hready_block = 1'b0;
      @(negedge clk);
      check_idle("after_ignored");

      // Reset pulsed during a stalled ACCESS.
      sb_q.push_back('{1'b0, 32'h0000_0BAD, 32'h0, 32'h0, 20, 1'b0, 16'h0BAD, 32'h0, 1'b0, 0, 0, 1'b0});
      @(posedge clk); #1;
      bus.ahbls_haddr  = 32'h0000_0BAD;
      bus.ahbls_hwrite = 1'b0;
      bus.ahbls_htrans = 2'b10;
      @(posedge clk); #1;
      idle_addr();
      for (int i = 0; i < 10 && !(bus.apbm_psel && bus.apbm_penable); i++) @(negedge clk);
      check("rst_reach_access", bus.apbm_psel && bus.apbm_penable, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check_idle("async_reset");
      check("async_reset_paddr", bus.apbm_paddr, 16'h0);
      @(negedge clk);
      sb_q.delete();
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      check("sb_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ahbl_to_apb.md
AHBL_TO_APB -- requirements
Module: ahbl_to_apb

Interface
REQ-001 Parameter W_HADDR, default 32, SHALL set the AHB-Lite address width.
REQ-002 Parameter W_PADDR, default 16, SHALL set the APB address width, W_PADDR <= W_HADDR.
REQ-003 Parameter W_DATA, default 32, SHALL set the read and write data width of both ports.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-006 ahbls_hready  in  1  SHALL be the bus-level HREADY, qualifying address phases.
REQ-007 ahbls_hready_resp  out  1  SHALL be this slave's HREADYOUT.
REQ-008 ahbls_hresp  out  1  SHALL be the error response.
REQ-009 ahbls_haddr  in  W_HADDR  SHALL be the address-phase address.
REQ-010 ahbls_hwrite  in  1  SHALL be the address-phase write flag.
REQ-011 ahbls_htrans  in  2  SHALL be the transfer type; bit 1 set means NSEQ/SEQ.
REQ-012 ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock  in  3/3/4/1  SHALL be accepted and ignored.
REQ-013 ahbls_hwdata  in  W_DATA  SHALL be the data-phase write data.
REQ-014 ahbls_hrdata  out  W_DATA  SHALL be the read data.
REQ-015 apbm_paddr  out  W_PADDR  SHALL be the APB address.
REQ-016 apbm_psel, apbm_penable, apbm_pwrite  out  1 each  SHALL be the APB control signals.
REQ-017 apbm_pwdata  out  W_DATA  SHALL be the APB write data.
REQ-018 apbm_prdata  in  W_DATA  SHALL be the APB read data.
REQ-019 apbm_pready, apbm_pslverr  in  1 each  SHALL be the APB completion and error signals.

Function
REQ-020 The block SHALL have states IDLE, WDATA, SETUP, ACCESS, ERR1 and ERR2.
REQ-021 A transfer SHALL be accepted when ahbls_hready && ahbls_htrans[1] in IDLE, in ACCESS completing without error, or in ERR2. On acceptance the block SHALL latch haddr[W_PADDR-1:0] into apbm_paddr and latch hwrite into apbm_pwrite.
REQ-022 Accepting a write SHALL move to WDATA; accepting a read SHALL move to SETUP. A cycle with no acceptance SHALL move to IDLE.
REQ-023 WDATA SHALL register ahbls_hwdata into apbm_pwdata and move to SETUP unconditionally.
REQ-024 SETUP SHALL drive psel=1, penable=0, then move to ACCESS unconditionally.
REQ-025 ACCESS SHALL drive psel=1, penable=1 and remain in ACCESS while pready=0.
REQ-026 ACCESS with pready=1 and pslverr=0 SHALL drive hready_resp=1, hresp=0, and hrdata=apbm_prdata.
REQ-027 ACCESS with pready=1 and pslverr=1 SHALL move to ERR1 and drive hready_resp=0 in that cycle.
REQ-028 ERR1 SHALL drive hready_resp=0, hresp=1, psel=0, then move to ERR2.
REQ-029 ERR2 SHALL drive hready_resp=1, hresp=1, psel=0.
REQ-030 hready_resp SHALL be 1 in IDLE and ERR2, and 0 in WDATA, SETUP, ERR1, and ACCESS while pready=0.
REQ-031 hresp SHALL be 0 outside ERR1/ERR2.
REQ-032 hrdata SHALL be all-zero outside ACCESS.
REQ-033 psel and penable SHALL be 0 in IDLE, WDATA, ERR1 and ERR2.
REQ-034 paddr, pwrite and pwdata SHALL hold stable from SETUP through ACCESS completion.
REQ-035 Read latency SHALL be 1 AHB wait state plus APB wait states; write latency SHALL be 2 AHB wait states plus APB wait states.
REQ-036 IDLE/BUSY transfers (htrans[1]=0), and any address phase with ahbls_hready=0, SHALL be ignored with no APB activity.
REQ-037 A transfer accepted in the completing ACCESS cycle SHALL start back-to-back with no IDLE cycle.
REQ-038 Address bits above W_PADDR SHALL be discarded.

Reset
REQ-039 rst_n low SHALL asynchronously force state IDLE and clear paddr, pwrite, pwdata, psel and penable to 0.
REQ-040 While rst_n is low, outputs SHALL be hready_resp=1, hresp=0, hrdata=0.
REQ-041 Reset asserted mid-transfer SHALL abandon that transfer; the first cycle after deassertion SHALL be IDLE.

Verification
REQ-042 Read of 0x4000_1234 with pready=1, prdata=0xCAFEF00D -> paddr=0x1234; SETUP at A+1, ACCESS at A+2; hrdata=0xCAFEF00D with hready_resp=1 at A+2.
REQ-043 Write 0xDEADBEEF to 0x0010 with pready held low 3 cycles -> pwdata=0xDEADBEEF from SETUP; penable high 4 cycles; hready_resp low 5 data-phase cycles.
REQ-044 Read with pslverr=1 -> ERR1 (hready_resp=0, hresp=1), then ERR2 (hready_resp=1, hresp=1), then IDLE.
REQ-045 Back-to-back write then read, each presented on the completing cycle -> no IDLE between the two ACCESS phases; psel falls only after the read completes.
REQ-046 htrans=BUSY, and htrans=NSEQ with hready=0 -> psel stays 0 and hready_resp stays 1.
REQ-047 rst_n pulsed low during ACCESS -> psel=0, penable=0 and hready_resp=1 immediately, without waiting for a clock edge.
